sparse_operand_loader: RTL and testbench

- Upstream feeder for the 4x4 sparse systolic multiplier array.
- Accepts a serial 8-bit byte stream after a start pulse: first matrix B (16 elements, row-major), then matrix A (16 elements, row-major).
- Holds B stationary on the array's m2c1..m2c16 inputs with per-element nonzero flags f11..f44.
- Streams A rows onto m1i1..m1i4, optionally diagonally skewed for registered computation units.

---
 rtl/sparse_operand_loader.sv | 200 ++++++++++++++++++++
 tb/tb_sparse_operand_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sparse_operand_loader.sv
// Serial byte loader for the 4x4 sparse systolic array: captures B (held stationary with
// nonzero flags) then A, and streams A rows onto the array, optionally diagonally skewed.
module sparse_operand_loader #(
  parameter int DW   = 8,
  parameter int SKEW = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] m2c1,  output logic [DW-1:0] m2c2,
  output logic [DW-1:0] m2c3,  output logic [DW-1:0] m2c4,
  output logic [DW-1:0] m2c5,  output logic [DW-1:0] m2c6,
  output logic [DW-1:0] m2c7,  output logic [DW-1:0] m2c8,
  output logic [DW-1:0] m2c9,  output logic [DW-1:0] m2c10,
  output logic [DW-1:0] m2c11, output logic [DW-1:0] m2c12,
  output logic [DW-1:0] m2c13, output logic [DW-1:0] m2c14,
  output logic [DW-1:0] m2c15, output logic [DW-1:0] m2c16,
  output logic          f11, output logic f12, output logic f13, output logic f14,
  output logic          f21, output logic f22, output logic f23, output logic f24,
  output logic          f31, output logic f32, output logic f33, output logic f34,
  output logic          f41, output logic f42, output logic f43, output logic f44,
  output logic [DW-1:0] m1i1,
  output logic [DW-1:0] m1i2,
  output logic [DW-1:0] m1i3,
  output logic [DW-1:0] m1i4,
  output logic          row_valid,
  output logic [1:0]    row_idx,
  output logic [4:0]    nnz_count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_A = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] T_LAST = (SKEW != 0) ? 3'd6 : 3'd3;

  state_e        state_q, state_d;
  logic [3:0]    beat_q, beat_d;
  logic [2:0]    t_q, t_d;
  logic          armed_q;
  logic [4:0]    nnz_q, nnz_d;
  logic [DW-1:0] b_q [16];
  logic [DW-1:0] b_d [16];
  logic [DW-1:0] a_q [16];
  logic [DW-1:0] a_d [16];
  logic [15:0]   f_q, f_d;
  logic [DW-1:0] m1i_q [4];
  logic [DW-1:0] m1i_d [4];
  logic          in_ready_q, in_ready_d;
  logic          row_valid_q, row_valid_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept_s;
  logic          last_beat_s;

  assign accept_s    = in_valid & in_ready_q;
  assign last_beat_s = accept_s & (beat_q == 4'd15);

  // State register; armed_q masks a start coinciding with reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= 4'd0;
      t_q         <= 3'd0;
      armed_q     <= 1'b0;
      nnz_q       <= 5'd0;
      f_q         <= 16'd0;
      in_ready_q  <= 1'b0;
      row_valid_q <= 1'b0;
      row_idx_q   <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        b_q[i] <= {DW{1'b0}};
        a_q[i] <= {DW{1'b0}};
      end
      for (int i = 0; i < 4; i++) begin
        m1i_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      t_q         <= t_d;
      armed_q     <= 1'b1;
      nnz_q       <= nnz_d;
      f_q         <= f_d;
      in_ready_q  <= in_ready_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      b_q         <= b_d;
      a_q         <= a_d;
      m1i_q       <= m1i_d;
    end
  end

  // Next-state logic together with the load datapath (beat counter, B/A capture, nnz).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    nnz_d   = nnz_q;
    f_d     = f_q;
    b_d     = b_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          state_d = S_LOAD_B;
          beat_d  = 4'd0;
          nnz_d   = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_B: begin
        if (accept_s) begin
          b_d[beat_q]  = in_data;
          f_d[beat_q]  = (in_data != {DW{1'b0}});
          nnz_d        = nnz_q + ((in_data != {DW{1'b0}}) ? 5'd1 : 5'd0);
          beat_d       = beat_q + 4'd1;
          state_d      = last_beat_s ? S_LOAD_A : S_LOAD_B;
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_A: begin
        if (accept_s) begin
          a_d[beat_q] = in_data;
          beat_d      = beat_q + 4'd1;
          state_d     = last_beat_s ? S_STREAM : S_LOAD_A;
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_STREAM: state_d = (t_q == T_LAST) ? S_DONE : S_STREAM;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if ((state_q == S_STREAM) && (state_d == S_STREAM)) begin
      t_d = t_q + 3'd1;
    end else begin
      t_d = 3'd0;
    end
  end

  // Output logic: every output is precomputed from the next state so it comes straight off a flop.
  always_comb begin
    in_ready_d  = (state_d == S_LOAD_B) || (state_d == S_LOAD_A);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    row_valid_d = (state_d == S_STREAM) && (t_d <= 3'd3);
    row_idx_d   = row_valid_d ? t_d[1:0] : 2'd0;
    for (int kk = 0; kk < 4; kk++) begin
      m1i_d[kk] = {DW{1'b0}};
      if (state_d != S_STREAM) begin
        m1i_d[kk] = {DW{1'b0}};
      end else if (SKEW == 0) begin
        m1i_d[kk] = a_q[{t_d[1:0], 2'(kk)}];
      end else if ((t_d >= 3'(kk)) && ((t_d - 3'(kk)) <= 3'd3)) begin
        // Element k trails element 1 by k-1 cycles to form the diagonal wavefront.
        m1i_d[kk] = a_q[{2'(t_d - 3'(kk)), 2'(kk)}];
      end else begin
        m1i_d[kk] = {DW{1'b0}};
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign row_valid = row_valid_q;
  assign row_idx   = row_idx_q;
  assign nnz_count = nnz_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m1i1 = m1i_q[0];
  assign m1i2 = m1i_q[1];
  assign m1i3 = m1i_q[2];
  assign m1i4 = m1i_q[3];

  assign m2c1  = b_q[0];  assign m2c2  = b_q[1];  assign m2c3  = b_q[2];  assign m2c4  = b_q[3];
  assign m2c5  = b_q[4];  assign m2c6  = b_q[5];  assign m2c7  = b_q[6];  assign m2c8  = b_q[7];
  assign m2c9  = b_q[8];  assign m2c10 = b_q[9];  assign m2c11 = b_q[10]; assign m2c12 = b_q[11];
  assign m2c13 = b_q[12]; assign m2c14 = b_q[13]; assign m2c15 = b_q[14]; assign m2c16 = b_q[15];

  assign f11 = f_q[0];  assign f12 = f_q[1];  assign f13 = f_q[2];  assign f14 = f_q[3];
  assign f21 = f_q[4];  assign f22 = f_q[5];  assign f23 = f_q[6];  assign f24 = f_q[7];
  assign f31 = f_q[8];  assign f32 = f_q[9];  assign f33 = f_q[10]; assign f34 = f_q[11];
  assign f41 = f_q[12]; assign f42 = f_q[13]; assign f43 = f_q[14]; assign f44 = f_q[15];

endmodule

// File: tb/tb_sparse_operand_loader.sv
// Directed bench for sparse_operand_loader: one SKEW=0 and one SKEW=1 instance share the
// same stimulus; expected values are hand-computed constants plus a small row/skew model.
module tb_sparse_operand_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic in_ready0, row_valid0, busy0, done0, in_ready1, row_valid1, busy1, done1;
  logic [1:0] row_idx0, row_idx1;
  logic [4:0] nnz0, nnz1;
  logic [15:0] f_0, f_1;
  logic [15:0][7:0] m2c_0, m2c_1;
  logic [3:0][7:0] m1i_0, m1i_1;

  logic [7:0] b_v [16];
  logic [7:0] a_v [16];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sparse_operand_loader #(.DW(8), .SKEW(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .m2c1(m2c_0[0]), .m2c2(m2c_0[1]), .m2c3(m2c_0[2]), .m2c4(m2c_0[3]),
    .m2c5(m2c_0[4]), .m2c6(m2c_0[5]), .m2c7(m2c_0[6]), .m2c8(m2c_0[7]),
    .m2c9(m2c_0[8]), .m2c10(m2c_0[9]), .m2c11(m2c_0[10]), .m2c12(m2c_0[11]),
    .m2c13(m2c_0[12]), .m2c14(m2c_0[13]), .m2c15(m2c_0[14]), .m2c16(m2c_0[15]),
    .f11(f_0[0]), .f12(f_0[1]), .f13(f_0[2]), .f14(f_0[3]),
    .f21(f_0[4]), .f22(f_0[5]), .f23(f_0[6]), .f24(f_0[7]),
    .f31(f_0[8]), .f32(f_0[9]), .f33(f_0[10]), .f34(f_0[11]),
    .f41(f_0[12]), .f42(f_0[13]), .f43(f_0[14]), .f44(f_0[15]),
    .m1i1(m1i_0[3]), .m1i2(m1i_0[2]), .m1i3(m1i_0[1]), .m1i4(m1i_0[0]),
    .row_valid(row_valid0), .row_idx(row_idx0), .nnz_count(nnz0), .busy(busy0), .done(done0)
  );

  sparse_operand_loader #(.DW(8), .SKEW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .m2c1(m2c_1[0]), .m2c2(m2c_1[1]), .m2c3(m2c_1[2]), .m2c4(m2c_1[3]),
    .m2c5(m2c_1[4]), .m2c6(m2c_1[5]), .m2c7(m2c_1[6]), .m2c8(m2c_1[7]),
    .m2c9(m2c_1[8]), .m2c10(m2c_1[9]), .m2c11(m2c_1[10]), .m2c12(m2c_1[11]),
    .m2c13(m2c_1[12]), .m2c14(m2c_1[13]), .m2c15(m2c_1[14]), .m2c16(m2c_1[15]),
    .f11(f_1[0]), .f12(f_1[1]), .f13(f_1[2]), .f14(f_1[3]),
    .f21(f_1[4]), .f22(f_1[5]), .f23(f_1[6]), .f24(f_1[7]),
    .f31(f_1[8]), .f32(f_1[9]), .f33(f_1[10]), .f34(f_1[11]),
    .f41(f_1[12]), .f42(f_1[13]), .f43(f_1[14]), .f44(f_1[15]),
    .m1i1(m1i_1[3]), .m1i2(m1i_1[2]), .m1i3(m1i_1[1]), .m1i4(m1i_1[0]),
    .row_valid(row_valid1), .row_idx(row_idx1), .nnz_count(nnz1), .busy(busy1), .done(done1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {m1i1,m1i2,m1i3,m1i4} at stream cycle t for the given skew setting.
  function automatic logic [31:0] exp_m1i(input int skew, input int t);
    logic [31:0] res;
    int r;
    res = 32'd0;
    for (int k = 0; k < 4; k++) begin
      r = (skew != 0) ? (t - k) : t;
      if (r >= 0 && r <= 3) res[31 - 8*k -: 8] = a_v[4*r + k];
    end
    return res;
  endfunction

  // Pulse start, then feed nbeats of B-then-A; gap inserts 3 idle cycles after every odd beat.
  task automatic load(input bit gap, input int nbeats);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("in_ready_after_start", {30'd0, in_ready1, in_ready0}, 32'd3);
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 16) ? b_v[i] : a_v[i - 16];
      step();
      in_valid = 1'b0;
      in_data  = 8'hA5;
      if (gap && (i % 2 == 1) && (i != nbeats - 1)) begin
        repeat (3) step();
      end
    end
  endtask

  // Walk both instances through their stream windows starting at t=0.
  task automatic check_stream(input string tag);
    for (int t = 0; t < 9; t++) begin
      check_val({tag, "_m1i_s0"}, m1i_0, exp_m1i(0, t));
      check_val({tag, "_m1i_s1"}, m1i_1, exp_m1i(1, t));
      check_val({tag, "_rv_s0"}, {31'd0, row_valid0}, {31'd0, t < 4});
      check_val({tag, "_rv_s1"}, {31'd0, row_valid1}, {31'd0, t < 4});
      if (t < 4) begin
        check_val({tag, "_ridx_s0"}, {30'd0, row_idx0}, t);
        check_val({tag, "_ridx_s1"}, {30'd0, row_idx1}, t);
      end
      check_val({tag, "_done_s0"}, {31'd0, done0}, {31'd0, t == 4});
      check_val({tag, "_done_s1"}, {31'd0, done1}, {31'd0, t == 7});
      check_val({tag, "_busy_s0"}, {31'd0, busy0}, {31'd0, t < 5});
      check_val({tag, "_busy_s1"}, {31'd0, busy1}, {31'd0, t < 8});
      check_val({tag, "_in_ready"}, {30'd0, in_ready1, in_ready0}, 32'd0);
      if (t == 1) check_val({tag, "_s1_t1"}, m1i_1, {8'd21, 8'd18, 8'd0, 8'd0});
      if (t == 3) check_val({tag, "_s1_t3"}, m1i_1, {8'd29, 8'd26, 8'd23, 8'd20});
      if (t == 6) check_val({tag, "_s1_t6"}, m1i_1, {8'd0, 8'd0, 8'd0, 8'd32});
      start = (t == 2);
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      b_v[i] = 8'(i + 1);
      a_v[i] = 8'(i + 17);
    end
    repeat (3) step();
    check_val("rst_busy", {30'd0, busy1, busy0}, 32'd0);
    check_val("rst_in_ready", {30'd0, in_ready1, in_ready0}, 32'd0);
    check_val("rst_nnz", nnz0, 32'd0);
    check_val("rst_flags", f_0, 32'd0);
    check_val("rst_m1i", m1i_0, 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Dense load.
    load(1'b0, 32);
    check_val("dense_nnz", nnz0, 32'd16);
    check_val("dense_flags", f_0, 32'h0000_FFFF);
    check_val("dense_m2c1", m2c_0[0], 32'd1);
    check_val("dense_m2c16", m2c_0[15], 32'd16);
    check_val("s1_t0", m1i_1, {8'd17, 8'd0, 8'd0, 8'd0});
    check_stream("dense");
    check_val("hold_m2c6", m2c_0[5], 32'd6);
    check_val("hold_flags", f_1, 32'h0000_FFFF);
    check_val("hold_nnz", nnz1, 32'd16);

    // Reset in the middle of LOAD_A.
    for (int i = 0; i < 16; i++) b_v[i] = 8'(i + 40);
    load(1'b0, 20);
    check_val("pre_rst_m2c1", m2c_0[0], 32'd40);
    rst_n = 1'b0;
    #1;
    check_val("midrst_m2c1", m2c_0[0], 32'd0);
    check_val("midrst_flags", f_0, 32'd0);
    check_val("midrst_nnz", nnz1, 32'd0);
    check_val("midrst_busy", {30'd0, busy1, busy0}, 32'd0);
    check_val("midrst_in_ready", {30'd0, in_ready1, in_ready0}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Identity B with handshake gaps.
    for (int i = 0; i < 16; i++) b_v[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
    load(1'b1, 32);
    check_val("ident_flags", f_0, 32'h0000_8421);
    check_val("ident_nnz", nnz0, 32'd4);
    check_val("ident_m2c", {m2c_0[0], m2c_0[5], m2c_0[10], m2c_0[15]}, 32'h0101_0101);
    check_val("ident_m2c2", m2c_0[1], 32'd0);
    check_stream("gap");
    check_val("ident_hold_flags", f_1, 32'h0000_8421);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
